// File: rtl/ifu_idu_inst_queue.sv
// Instruction queue decoupling fetch (IFU) from decode (IDU): an in-order circular
// buffer of {pc, inst} pairs with null-fetch dropping, redirect flush and perf counters.
module ifu_idu_inst_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_WIDTH-1:0]    in_pc,
    input  logic [DATA_WIDTH-1:0]    in_inst,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_WIDTH-1:0]    out_pc,
    output logic [DATA_WIDTH-1:0]    out_inst,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_WIDTH-1:0]     fetch_cnt,
    output logic [CNT_WIDTH-1:0]     bubble_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic fetch_hs;
    logic do_push;
    logic do_null;
    logic do_pop;

    // Ready depends only on occupancy and flush, never on out_ready.
    assign in_ready  = (count < FULL) && !flush;
    assign out_valid = (count != '0) && !flush;

    assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;
    assign out_inst = out_valid ? inst_mem[rd_ptr] : '0;

    assign fetch_hs = in_valid && in_ready;
    assign do_push  = fetch_hs && (in_inst != '0);
    assign do_null  = fetch_hs && (in_inst == '0);
    assign do_pop   = out_valid && out_ready;

    // Storage is deliberately left unreset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                fetch_cnt <= fetch_cnt + 1'b1;
            end
            if (do_null) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifu_idu_inst_queue.sv
// Directed self-checking bench for ifu_idu_inst_queue: one task per scenario,
// expected values hand-computed from the queue's intended behaviour.
module tb_ifu_idu_inst_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    int n_cmp;
    int n_fail;

    ifu_idu_inst_queue #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH(4),
        .CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc(in_pc),
        .in_inst(in_inst),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
        .count(count),
        .fetch_cnt(fetch_cnt),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_fetch_cnt: got %0d expected 0", fetch_cnt); end
        n_cmp++; if (bubble_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_bubble_cnt: got %0d expected 0", bubble_cnt); end
        n_cmp++; if (out_pc !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_out_pc: got %h expected 0", out_pc); end
    endtask

    task automatic test_basic();
        logic [31:0] pcs   [3];
        logic [31:0] insts [3];
        pcs   = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
        insts = '{32'h0000_0413, 32'h0010_0493, 32'h0094_0533};
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_pc = pcs[k]; in_inst = insts[k];
            tick();
        end
        in_valid = 1'b0; in_pc = '0; in_inst = '0;
        #1;
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("[TB] FAIL basic_count: got %0d expected 3", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("[TB] FAIL basic_fetch_cnt: got %0d expected 3", fetch_cnt); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== pcs[k] || out_inst !== insts[k]) begin
                n_fail++; $display("[TB] FAIL basic_drain%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", k, out_valid, out_pc, out_inst, pcs[k], insts[k]);
            end
            tick();
        end
        out_ready = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_empty: got count=%0d v=%b expected count=0 v=0", count, out_valid); end
    endtask

    task automatic test_full();
        logic [31:0] pcs   [5];
        logic [31:0] insts [5];
        pcs   = '{32'h8000_0010, 32'h8000_0014, 32'h8000_0018, 32'h8000_001c, 32'h8000_0020};
        insts = '{32'h0010_0013, 32'h0010_0014, 32'h0010_0015, 32'h0010_0016, 32'h0050_0013};
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_pc = pcs[k]; in_inst = insts[k];
            tick();
        end
        in_pc = pcs[4]; in_inst = insts[4];
        #1;
        n_cmp++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_stall: got count=%0d rdy=%b expected count=4 rdy=0", count, in_ready); end
        tick();
        out_ready = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd4 || in_ready !== 1'b0 || out_pc !== pcs[0]) begin
            n_fail++; $display("[TB] FAIL full_held: got count=%0d rdy=%b pc=%h expected count=4 rdy=0 pc=%h", count, in_ready, out_pc, pcs[0]);
        end
        tick();
        #1;
        n_cmp++; if (count !== 3'd3 || in_ready !== 1'b1 || out_pc !== pcs[1]) begin
            n_fail++; $display("[TB] FAIL full_reopen: got count=%0d rdy=%b pc=%h expected count=3 rdy=1 pc=%h", count, in_ready, out_pc, pcs[1]);
        end
        tick();
        in_valid = 1'b0; in_pc = '0; in_inst = '0;
        for (int k = 2; k < 5; k++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== pcs[k] || out_inst !== insts[k]) begin
                n_fail++; $display("[TB] FAIL full_order%0d: got pc=%h inst=%h expected pc=%h inst=%h", k, out_pc, out_inst, pcs[k], insts[k]);
            end
            tick();
        end
        out_ready = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || fetch_cnt !== 32'd8) begin n_fail++; $display("[TB] FAIL full_end: got count=%0d fetch=%0d expected count=0 fetch=8", count, fetch_cnt); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h8000_0000 + 32'(4 * k);
            in_inst  = 32'h0000_0093 + (32'(k) << 20);
            #1;
            if (k == 0) begin
                n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_start: got count=%0d v=%b expected count=0 v=0", count, out_valid); end
            end else begin
                n_cmp++; if (count !== 3'd1 || in_ready !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h8000_0000 + 32'(4 * (k - 1))) begin
                    n_fail++; $display("[TB] FAIL b2b_step%0d: got count=%0d rdy=%b v=%b pc=%h expected count=1 rdy=1 v=1 pc=%h", k, count, in_ready, out_valid, out_pc, 32'h8000_0000 + 32'(4 * (k - 1)));
                end
            end
            tick();
        end
        in_valid = 1'b0; in_pc = '0; in_inst = '0;
        #1;
        n_cmp++; if (count !== 3'd1 || out_pc !== 32'h8000_001c || out_inst !== 32'h0070_0093) begin
            n_fail++; $display("[TB] FAIL b2b_last: got count=%0d pc=%h inst=%h expected count=1 pc=8000001c inst=00700093", count, out_pc, out_inst);
        end
        tick();
        #1;
        n_cmp++; if (count !== 3'd0 || fetch_cnt !== 32'd16) begin n_fail++; $display("[TB] FAIL b2b_end: got count=%0d fetch=%0d expected count=0 fetch=16", count, fetch_cnt); end
    endtask

    task automatic test_bubbles();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h8000_0040 + 32'(4 * k);
            in_inst  = (k % 2 == 0) ? 32'h0000_0113 + 32'(k) : 32'h0;
            #1;
            if (k % 2 == 1) begin
                n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0040 + 32'(4 * (k - 1)) || out_inst !== 32'h0000_0113 + 32'(k - 1)) begin
                    n_fail++; $display("[TB] FAIL bubble_out%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", k, out_valid, out_pc, out_inst, 32'h8000_0040 + 32'(4 * (k - 1)), 32'h0000_0113 + 32'(k - 1));
                end
            end else begin
                n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bubble_gap%0d: got v=%b inst=%h expected v=0", k, out_valid, out_inst); end
            end
            tick();
        end
        in_valid = 1'b0; in_pc = '0; in_inst = '0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("[TB] FAIL bubble_empty: got v=%b count=%0d expected v=0 count=0", out_valid, count); end
        n_cmp++; if (bubble_cnt !== 32'd4) begin n_fail++; $display("[TB] FAIL bubble_cnt: got %0d expected 4", bubble_cnt); end
        n_cmp++; if (fetch_cnt !== 32'd20) begin n_fail++; $display("[TB] FAIL bubble_fetch_cnt: got %0d expected 20", fetch_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_pc = 32'h8000_0080 + 32'(4 * k); in_inst = 32'h0000_0213 + 32'(k);
            tick();
        end
        flush = 1'b1; in_pc = 32'h8000_0200; in_inst = 32'h0000_0313;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_pc !== 32'd0) begin
            n_fail++; $display("[TB] FAIL flush_cycle: got v=%b rdy=%b pc=%h expected v=0 rdy=0 pc=0", out_valid, in_ready, out_pc);
        end
        tick();
        flush = 1'b0; in_pc = 32'h8000_0100; in_inst = 32'h0000_0393;
        #1;
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL flush_after: got count=%0d v=%b rdy=%b expected count=0 v=0 rdy=1", count, out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0; in_pc = '0; in_inst = '0;
        #1;
        n_cmp++; if (count !== 3'd1 || out_pc !== 32'h8000_0100 || out_inst !== 32'h0000_0393) begin
            n_fail++; $display("[TB] FAIL flush_first: got count=%0d pc=%h inst=%h expected count=1 pc=80000100 inst=00000393", count, out_pc, out_inst);
        end
        n_cmp++; if (fetch_cnt !== 32'd24) begin n_fail++; $display("[TB] FAIL flush_fetch_cnt: got %0d expected 24", fetch_cnt); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_drain: got count=%0d expected 0", count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_pc = 32'h8000_0300 + 32'(4 * k); in_inst = 32'h0000_0513 + 32'(k);
            tick();
        end
        in_pc = 32'h8000_0308; in_inst = 32'h0000_0593;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd2 || fetch_cnt !== 32'd26 || bubble_cnt !== 32'd4) begin
            n_fail++; $display("[TB] FAIL rstmid_pre: got count=%0d fetch=%0d bubble=%0d expected 2/26/4", count, fetch_cnt, bubble_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        #1;
        n_cmp++; if (count !== 3'd0 || fetch_cnt !== 32'd0 || bubble_cnt !== 32'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rstmid_post: got count=%0d fetch=%0d bubble=%0d v=%b expected 0/0/0/0", count, fetch_cnt, bubble_cnt, out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("[TB] FAIL rstmid_leak%0d: got v=%b count=%0d pc=%h expected v=0 count=0", k, out_valid, count, out_pc); end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_bubbles();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
